// File: rtl/disp7_scan_ctrl.sv
// disp7_scan_ctrl
// Seven-segment display controller for the processor result bus. A value is
// captured on a valid/ready handshake and rendered either as hex nibbles or as
// unsigned decimal digits (sequential double-dabble conversion, one data bit
// per clock). Optional leading-zero blanking. One display buffer feeds both a
// static per-digit segment bus and a time-multiplexed scanned bus.
//
// Ports
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   valid_i    data_i/mode_i/blank_i valid, taken when valid_i && ready_o
//   data_i     value to display (DATA_W bits)
//   mode_i     0 = hex, 1 = unsigned decimal
//   blank_i    1 = blank leading zeros
//   ready_o    controller idle and able to accept
//   ovf_o      last decimal value did not fit in DIGITS digits
//   seg_all_o  static segments, digit k at [7k+6:7k], gfedcba
//   seg_o      scanned segments of the active digit
//   an_o       scanned one-hot digit enable
module disp7_scan_ctrl #(
    parameter int DIGITS     = 8,
    parameter int DATA_W     = 32,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  mode_i,
    input  logic                  blank_i,
    output logic                  ready_o,
    output logic                  ovf_o,
    output logic [7*DIGITS-1:0]   seg_all_o,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     an_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int HEX_W = (DATA_W < BCD_W) ? DATA_W : BCD_W;

    localparam logic [6:0]        SEG_ZERO  = (ACTIVE_LOW != 0) ? 7'h40 : 7'h3F;
    localparam logic [6:0]        SEG_BLANK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] AN_RESET  = (ACTIVE_LOW != 0) ? ~DIGITS'(1) : DIGITS'(1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic                blankReq_q, blankReq_d;
    logic                ovfAcc_q, ovfAcc_d;
    logic [BCD_W-1:0]    buf_q, buf_d;
    logic                blank_q, blank_d;
    logic                ovf_q, ovf_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic                accept;
    logic                convDone;
    logic                scanWrap;
    logic [BCD_W-1:0]    bcdShift;
    logic                bcdOut;
    logic [BCD_W-1:0]    hexVal;
    logic [7*DIGITS-1:0] segAll;

    // Active-low gfedcba glyphs, flipped when the board drives segments high.
    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        logic [6:0] raw;
        case (n)
            4'h0: raw = 7'h40;
            4'h1: raw = 7'h79;
            4'h2: raw = 7'h24;
            4'h3: raw = 7'h30;
            4'h4: raw = 7'h19;
            4'h5: raw = 7'h12;
            4'h6: raw = 7'h02;
            4'h7: raw = 7'h78;
            4'h8: raw = 7'h00;
            4'h9: raw = 7'h10;
            4'hA: raw = 7'h08;
            4'hB: raw = 7'h03;
            4'hC: raw = 7'h46;
            4'hD: raw = 7'h21;
            4'hE: raw = 7'h06;
            default: raw = 7'h0E;
        endcase
        return (ACTIVE_LOW != 0) ? raw : ~raw;
    endfunction

    assign accept   = valid_i && (state_q == IDLE);
    assign convDone = (cnt_q == CNT_W'(DATA_W - 1));
    assign scanWrap = (presc_q == PRE_W'(SCAN_DIV - 1));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = mode_i ? CONV : LOAD;
            CONV:    if (convDone) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM-facing outputs
    always_comb begin
        ready_o   = (state_q == IDLE);
        ovf_o     = ovf_q;
        seg_all_o = segAll;
        seg_o     = seg_q;
        an_o      = an_q;
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift the next
    // data bit in. Whatever falls out of the top digit is lost decimal range.
    always_comb begin
        logic [BCD_W-1:0] adj;
        adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        bcdShift = {adj[BCD_W-2:0], shift_q[DATA_W-1]};
        bcdOut   = adj[BCD_W-1];
    end

    // Hex view of the captured value: zero-fill or truncate to the buffer.
    always_comb begin
        hexVal               = '0;
        hexVal[HEX_W-1:0]    = shift_q[HEX_W-1:0];
    end

    // Digit glyphs; walking down from the top tracks whether everything at and
    // above digit k is zero, which is exactly the leading-zero blanking rule.
    always_comb begin
        logic allZero;
        allZero = 1'b1;
        segAll  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            allZero = allZero && (buf_q[4*k +: 4] == 4'd0);
            if (blank_q && (k != 0) && allZero) segAll[7*k +: 7] = SEG_BLANK;
            else                                segAll[7*k +: 7] = hexSeg(buf_q[4*k +: 4]);
        end
    end

    // Datapath and scanner next-state
    always_comb begin
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        blankReq_d = blankReq_q;
        ovfAcc_d   = ovfAcc_q;
        buf_d      = buf_q;
        blank_d    = blank_q;
        ovf_d      = ovf_q;

        if (accept) begin
            shift_d    = data_i;
            mode_d     = mode_i;
            blankReq_d = blank_i;
            bcd_d      = '0;
            cnt_d      = '0;
            ovfAcc_d   = 1'b0;
        end else if (state_q == CONV) begin
            bcd_d   = bcdShift;
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
            if (bcdOut) ovfAcc_d = 1'b1;
        end else if (state_q == LOAD) begin
            buf_d   = mode_q ? bcd_q : hexVal;
            blank_d = blankReq_q;
            ovf_d   = mode_q && ovfAcc_q;
        end

        // The scanner free-runs regardless of what the FSM is doing.
        presc_d = scanWrap ? '0 : presc_q + PRE_W'(1);
        idx_d   = idx_q;
        if (scanWrap) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

        seg_d = segAll[7*int'(idx_q) +: 7];
        an_d  = (ACTIVE_LOW != 0) ? ~(DIGITS'(1) << idx_q) : (DIGITS'(1) << idx_q);
    end

    // Datapath and scanner registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            blankReq_q <= 1'b0;
            ovfAcc_q   <= 1'b0;
            buf_q      <= '0;
            blank_q    <= 1'b0;
            ovf_q      <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_ZERO;
            an_q       <= AN_RESET;
        end else begin
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            blankReq_q <= blankReq_d;
            ovfAcc_q   <= ovfAcc_d;
            buf_q      <= buf_d;
            blank_q    <= blank_d;
            ovf_q      <= ovf_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

endmodule
